// File: rtl/fft8_scheduler_if.sv
// Bundle of the load, unload and external-butterfly signals of the 8-point FFT scheduler.
// The slave modport is the scheduler. The master modport is its environment: the sample source, the result sink and the butterfly datapath.
interface fft8_if #(
    parameter int N = 4
);
    localparam int W = 2 ** N;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_r;
    logic [W-1:0] in_i;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_r;
    logic [W-1:0] out_i;
    logic [2:0]   out_idx;
    logic         frame_done;

    logic [W-1:0] bf_a_r;
    logic [W-1:0] bf_a_i;
    logic [W-1:0] bf_b_r;
    logic [W-1:0] bf_b_i;
    logic [1:0]   bf_tw;
    logic [W-1:0] bf_top_r;
    logic [W-1:0] bf_top_i;
    logic [W-1:0] bf_bot_r;
    logic [W-1:0] bf_bot_i;

    logic         busy;

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        input  bf_top_r, bf_top_i, bf_bot_r, bf_bot_i,
        output in_ready, out_valid, out_r, out_i, out_idx, frame_done,
        output bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_tw, busy
    );

    modport master (
        output in_valid, in_r, in_i, out_ready,
        output bf_top_r, bf_top_i, bf_bot_r, bf_bot_i,
        input  in_ready, out_valid, out_r, out_i, out_idx, frame_done,
        input  bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_tw, busy
    );
endinterface

// File: rtl/fft8_scheduler.sv
// In-place radix-2 DIT scheduler for an 8-point FFT. It loads samples in bit-reversed order and issues 12 butterflies to an external datapath.
// It then streams the bins out in natural order.
module fft8_scheduler #(
    parameter int N = 4
) (
    input  logic  clk,
    input  logic  reset,
    fft8_if.slave bus
);
    localparam int W = 2 ** N;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t       state_reg;
    logic [2:0]   load_cnt_reg;
    logic [2:0]   unload_cnt_reg;
    logic [3:0]   step_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         busy_reg;
    logic [W-1:0] mem_r_reg [8];
    logic [W-1:0] mem_i_reg [8];

    logic         load_fire;
    logic         out_fire;
    logic         computing;
    logic [2:0]   load_addr;
    logic [1:0]   bf_j;
    logic [2:0]   a_idx;
    logic [2:0]   b_idx;
    logic [1:0]   tw_sel;

    assign load_fire = in_ready_reg & bus.in_valid;
    assign out_fire  = out_valid_reg & bus.out_ready;
    assign computing = (state_reg == COMPUTE);
    assign load_addr = {load_cnt_reg[0], load_cnt_reg[1], load_cnt_reg[2]};
    assign bf_j      = step_reg[1:0];

    // The pair span doubles each stage: 1, 2, 4.
    always_comb begin
        a_idx  = '0;
        b_idx  = '0;
        tw_sel = '0;
        case (step_reg[3:2])
            2'd0: begin
                a_idx = {bf_j, 1'b0};
                b_idx = {bf_j, 1'b1};
            end
            2'd1: begin
                a_idx  = {bf_j[1], 1'b0, bf_j[0]};
                b_idx  = {bf_j[1], 1'b1, bf_j[0]};
                tw_sel = {bf_j[0], 1'b0};
            end
            default: begin
                a_idx  = {1'b0, bf_j};
                b_idx  = {1'b1, bf_j};
                tw_sel = bf_j;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= LOAD;
            load_cnt_reg   <= '0;
            unload_cnt_reg <= '0;
            step_reg       <= '0;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    in_ready_reg <= 1'b1;
                    if (load_fire) begin
                        load_cnt_reg <= load_cnt_reg + 3'd1;
                        if (load_cnt_reg == 3'd7) begin
                            state_reg    <= COMPUTE;
                            step_reg     <= '0;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    step_reg <= step_reg + 4'd1;
                    if (step_reg == 4'd11) begin
                        state_reg      <= UNLOAD;
                        step_reg       <= '0;
                        unload_cnt_reg <= '0;
                        out_valid_reg  <= 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        unload_cnt_reg <= unload_cnt_reg + 3'd1;
                        if (unload_cnt_reg == 3'd7) begin
                            state_reg     <= LOAD;
                            load_cnt_reg  <= '0;
                            out_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            in_ready_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    // Each store entry has its own writer. Load writes and butterfly write-backs never coincide.
    for (genvar gi = 0; gi < 8; gi++) begin : g_mem
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mem_r_reg[gi] <= '0;
                mem_i_reg[gi] <= '0;
            end else if (load_fire && (load_addr == 3'(gi))) begin
                mem_r_reg[gi] <= bus.in_r;
                mem_i_reg[gi] <= bus.in_i;
            end else if (computing && (a_idx == 3'(gi))) begin
                mem_r_reg[gi] <= bus.bf_top_r;
                mem_i_reg[gi] <= bus.bf_top_i;
            end else if (computing && (b_idx == 3'(gi))) begin
                mem_r_reg[gi] <= bus.bf_bot_r;
                mem_i_reg[gi] <= bus.bf_bot_i;
            end
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.busy       = busy_reg;
    assign bus.out_idx    = unload_cnt_reg;
    assign bus.out_r      = out_valid_reg ? mem_r_reg[unload_cnt_reg] : '0;
    assign bus.out_i      = out_valid_reg ? mem_i_reg[unload_cnt_reg] : '0;
    assign bus.frame_done = out_fire && (unload_cnt_reg == 3'd7);

    assign bus.bf_a_r = computing ? mem_r_reg[a_idx] : '0;
    assign bus.bf_a_i = computing ? mem_i_reg[a_idx] : '0;
    assign bus.bf_b_r = computing ? mem_r_reg[b_idx] : '0;
    assign bus.bf_b_i = computing ? mem_i_reg[b_idx] : '0;
    assign bus.bf_tw  = computing ? tw_sel : '0;
endmodule

// File: tb/tb_fft8_scheduler.sv
// Bench for fft8_scheduler. It provides a Q8 twiddle butterfly datapath and checks against a stage-by-stage radix-2 reference.
// It covers directed, random, stalled, reset-abort and back-to-back frames.
module tb_fft8_scheduler;
    logic clk;
    logic reset;
    int   checks    = 0;
    int   failures  = 0;
    int   fd_count  = 0;
    int   first_wait;

    fft8_if #(.N(4)) bus ();

    fft8_scheduler #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Butterfly: top = a + W8^k*b, bot = a - W8^k*b, with cos(pi/4) ~ 181/256.
    function automatic void bfly(input logic signed [15:0] ar, ai, br, bi, input logic [1:0] k,
                                 output logic signed [15:0] tr, ti, dr, di);
        int pr;
        int pi;
        case (k)
            2'd0: begin pr = int'(br); pi = int'(bi); end
            2'd1: begin
                pr = (int'(br) * 181 + int'(bi) * 181) >>> 8;
                pi = (int'(bi) * 181 - int'(br) * 181) >>> 8;
            end
            2'd2: begin pr = int'(bi); pi = -int'(br); end
            default: begin
                pr = (int'(bi) * 181 - int'(br) * 181) >>> 8;
                pi = (-int'(br) * 181 - int'(bi) * 181) >>> 8;
            end
        endcase
        tr = 16'(int'(ar) + pr);
        ti = 16'(int'(ai) + pi);
        dr = 16'(int'(ar) - pr);
        di = 16'(int'(ai) - pi);
    endfunction

    always_comb begin
        bfly(bus.bf_a_r, bus.bf_a_i, bus.bf_b_r, bus.bf_b_i, bus.bf_tw,
             bus.bf_top_r, bus.bf_top_i, bus.bf_bot_r, bus.bf_bot_i);
    end

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_count++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] bitrev(input int n);
        logic [2:0] v;
        v = 3'(n);
        return {v[0], v[1], v[2]};
    endfunction

    logic signed [15:0] xr [8];
    logic signed [15:0] xi [8];
    logic signed [15:0] mr [8];
    logic signed [15:0] mi [8];
    logic signed [15:0] er [8];
    logic signed [15:0] ei [8];

    task automatic randomize_frame();
        for (int n = 0; n < 8; n++) begin
            xr[n] = 16'($urandom_range(0, 4000)) - 16'sd2000;
            xi[n] = 16'($urandom_range(0, 4000)) - 16'sd2000;
        end
    endtask

    // Load, compute and unload one frame. With abort_c >= 0, pulse reset at that compute step and stop.
    task automatic run_frame(input bit toggle, input bit keep_valid, input int stall_k,
                             input bit use_model, input int abort_c, output int fw);
        int w;
        fw = 0;
        for (int n = 0; n < 8; n++) begin
            mr[bitrev(n)] = xr[n];
            mi[bitrev(n)] = xi[n];
        end
        for (int n = 0; n < 8; n++) begin
            if (toggle) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_r     = xr[n];
            bus.in_i     = xi[n];
            w = 0;
            while (bus.in_ready !== 1'b1 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (n == 0) fw = w;
            chk("load_ready_wait", 16'(w < 50), 16'd1);
            @(posedge clk); #1;
        end
        if (!keep_valid) bus.in_valid = 1'b0;

        for (int c = 0; c < 12; c++) begin
            int s, j, span, a, b, tw;
            s    = c / 4;
            j    = c % 4;
            span = 1 << s;
            a    = (j / span) * 2 * span + (j % span);
            b    = a + span;
            tw   = (j % span) * (4 / span);
            if (c == abort_c) begin
                reset = 1'b1;
                #1;
                chk("abort_busy", 16'(bus.busy), 16'd0);
                chk("abort_in_ready", 16'(bus.in_ready), 16'd0);
                chk("abort_bf_a_r", bus.bf_a_r, 16'd0);
                chk("abort_out_valid", 16'(bus.out_valid), 16'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            chk("bf_tw", 16'(bus.bf_tw), 16'(tw));
            chk("bf_a_r", bus.bf_a_r, mr[a]);
            chk("bf_a_i", bus.bf_a_i, mi[a]);
            chk("bf_b_r", bus.bf_b_r, mr[b]);
            chk("bf_b_i", bus.bf_b_i, mi[b]);
            chk("compute_in_ready", 16'(bus.in_ready), 16'd0);
            chk("compute_busy", 16'(bus.busy), 16'd1);
            chk("compute_out_valid", 16'(bus.out_valid), 16'd0);
            bfly(mr[a], mi[a], mr[b], mi[b], 2'(tw), mr[a], mi[a], mr[b], mi[b]);
            @(posedge clk); #1;
        end
        chk("latency_out_valid", 16'(bus.out_valid), 16'd1);
        if (use_model) begin
            er = mr;
            ei = mi;
        end

        for (int k = 0; k < 8; k++) begin
            chk("out_valid", 16'(bus.out_valid), 16'd1);
            chk("out_idx", 16'(bus.out_idx), 16'(k));
            chk("out_r", bus.out_r, er[k]);
            chk("out_i", bus.out_i, ei[k]);
            chk("unload_in_ready", 16'(bus.in_ready), 16'd0);
            if (k == stall_k) begin
                bus.out_ready = 1'b0;
                for (int q = 0; q < 5; q++) begin
                    @(posedge clk); #1;
                    chk("stall_idx", 16'(bus.out_idx), 16'(k));
                    chk("stall_out_r", bus.out_r, er[k]);
                    chk("stall_out_i", bus.out_i, ei[k]);
                    chk("stall_frame_done", 16'(bus.frame_done), 16'd0);
                end
                bus.out_ready = 1'b1;
            end
            chk("frame_done", 16'(bus.frame_done), 16'(k == 7));
            @(posedge clk); #1;
        end
        chk("post_out_valid", 16'(bus.out_valid), 16'd0);
        chk("post_in_ready", 16'(bus.in_ready), 16'd1);
    endtask

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_i      = '0;
        bus.out_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_frame_done", 16'(bus.frame_done), 16'd0);
        chk("rst_bf_tw", 16'(bus.bf_tw), 16'd0);
        chk("rst_bf_a_r", bus.bf_a_r, 16'd0);
        chk("rst_out_idx", 16'(bus.out_idx), 16'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("in_ready_before_edge", 16'(bus.in_ready), 16'd0);
        @(posedge clk); #1;
        chk("in_ready_after_reset", 16'(bus.in_ready), 16'd1);

        // Impulse: every bin is (100,0).
        for (int n = 0; n < 8; n++) begin
            xr[n] = (n == 0) ? 16'sd100 : 16'sd0;
            xi[n] = 16'sd0;
            er[n] = 16'sd100;
            ei[n] = 16'sd0;
        end
        run_frame(1'b0, 1'b0, 8, 1'b0, -1, first_wait);
        chk("fd_after_impulse", 16'(fd_count), 16'd1);
        $display("frame impulse done checks=%0d", checks);

        // DC: X[0] = 80 and all other bins 0.
        for (int n = 0; n < 8; n++) begin
            xr[n] = 16'sd10;
            xi[n] = 16'sd0;
            er[n] = (n == 0) ? 16'sd80 : 16'sd0;
            ei[n] = 16'sd0;
        end
        run_frame(1'b0, 1'b0, 8, 1'b0, -1, first_wait);
        $display("frame dc done checks=%0d", checks);

        // Random frame with a toggled in_valid and a 5-cycle stall at bin 3, then the same frame unstalled.
        randomize_frame();
        run_frame(1'b1, 1'b0, 3, 1'b1, -1, first_wait);
        $display("frame random stalled done checks=%0d", checks);
        run_frame(1'b0, 1'b0, 8, 1'b1, -1, first_wait);
        $display("frame random unstalled done checks=%0d", checks);

        // Reset at compute step 6, then a clean impulse frame.
        randomize_frame();
        run_frame(1'b0, 1'b0, 8, 1'b1, 6, first_wait);
        bus.in_valid = 1'b0;
        chk("fd_after_abort", 16'(fd_count), 16'd4);
        for (int n = 0; n < 8; n++) begin
            xr[n] = (n == 0) ? 16'sd100 : 16'sd0;
            xi[n] = 16'sd0;
            er[n] = 16'sd100;
            ei[n] = 16'sd0;
        end
        run_frame(1'b0, 1'b0, 8, 1'b0, -1, first_wait);
        $display("frame after reset abort done checks=%0d", checks);

        // Two back-to-back frames with in_valid held high.
        randomize_frame();
        run_frame(1'b0, 1'b1, 8, 1'b1, -1, first_wait);
        randomize_frame();
        run_frame(1'b0, 1'b1, 8, 1'b1, -1, first_wait);
        chk("b2b_first_accept_wait", 16'(first_wait), 16'd0);
        bus.in_valid = 1'b0;
        $display("frames back-to-back done checks=%0d", checks);

        @(posedge clk); #1;
        chk("frame_done_total", 16'(fd_count), 16'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
